rgu_seq: RTL and testbench

Reset generation sequencer that consumes the clock generator's MMCM `locked` status and distributes per-domain active-low resets in a fixed order. It sits beside the clock generator in the SCU and is clocked by the generated system clock. It holds all domain resets until lock has been stable for a programmable time, releases the domains one by one, and re-asserts every reset immediately on lock loss. It also supports per-domain software reset pulses while running.

---
 rtl/rgu_pkg.sv | 23 ++
 rtl/rgu_seq_if.sv | 24 ++
 rtl/rgu_sync2.sv | 24 ++
 rtl/rgu_seq.sv | 148 ++++++++++++++
 tb/tb_rgu_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rgu_pkg.sv
// Shared types and constants for the reset generation sequencer.
package rgu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rgu_state_e;

  localparam int unsigned LOCK_CNT_W = 8;

  localparam int unsigned DEF_N_DOM           = 4;
  localparam int unsigned DEF_LOCK_STABLE_CYC = 16;
  localparam int unsigned DEF_STAGE_GAP_CYC   = 8;
  localparam int unsigned DEF_SW_RST_CYC      = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgu_seq_if.sv
// Bundle of the sequencer's lock/request inputs and reset outputs.
interface rgu_seq_if
  import rgu_pkg::*;
#(
  parameter int unsigned N_DOM = DEF_N_DOM
) ();

  logic                  locked;
  logic [N_DOM-1:0]      sw_rst_req;
  logic [N_DOM-1:0]      dom_rstn;
  logic                  rst_done;
  logic [LOCK_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output locked, sw_rst_req,
    input  dom_rstn, rst_done, lock_loss_cnt
  );

  modport slave (
    input  locked, sw_rst_req,
    output dom_rstn, rst_done, lock_loss_cnt
  );

endinterface

// File: rtl/rgu_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module rgu_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rgu_seq.sv
// Reset sequencer: waits for stable MMCM lock, releases domains in order,
// drops everything on lock loss and services per-domain software pulses.
module rgu_seq
  import rgu_pkg::*;
#(
  parameter int unsigned N_DOM           = DEF_N_DOM,
  parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int unsigned STAGE_GAP_CYC   = DEF_STAGE_GAP_CYC,
  parameter int unsigned SW_RST_CYC      = DEF_SW_RST_CYC
) (
  input  logic                  sys_clk_i,
  input  logic                  por_rstn_i,
  input  logic                  locked_i,
  input  logic [N_DOM-1:0]      sw_rst_req_i,
  output logic [N_DOM-1:0]      dom_rstn_o,
  output logic                  rst_done_o,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int unsigned STB_W = cnt_w(LOCK_STABLE_CYC);
  localparam int unsigned GAP_W = cnt_w(STAGE_GAP_CYC);
  localparam int unsigned SW_W  = cnt_w(SW_RST_CYC + 1);

  logic locked_s;

  rgu_sync2 u_sync (
    .clk   (sys_clk_i),
    .rst_n (por_rstn_i),
    .d_i   (locked_i),
    .q_o   (locked_s)
  );

  rgu_state_e                  state_q, state_d;
  logic [STB_W-1:0]            stb_cnt_q, stb_cnt_d;
  logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
  logic [N_DOM-1:0][SW_W-1:0]  sw_cnt_q, sw_cnt_d;
  logic [N_DOM-1:0]            sw_req_q, sw_req_d;
  logic [N_DOM-1:0]            dom_rstn_q, dom_rstn_d;
  logic                        rst_done_q, rst_done_d;
  logic [LOCK_CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic [N_DOM-1:0]            next_rel;
  logic                        lock_loss_c;

  always_ff @(posedge sys_clk_i or negedge por_rstn_i) begin
    if (!por_rstn_i) begin
      state_q    <= IDLE;
      stb_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sw_cnt_q   <= '0;
      sw_req_q   <= '0;
      dom_rstn_q <= '0;
      rst_done_q <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stb_cnt_q  <= stb_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sw_cnt_q   <= sw_cnt_d;
      sw_req_q   <= sw_req_d;
      dom_rstn_q <= dom_rstn_d;
      rst_done_q <= rst_done_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Released domains always form a contiguous run of ones from bit 0.
  assign next_rel    = (dom_rstn_q << 1) | N_DOM'(1);
  assign lock_loss_c = !locked_s && ((state_q == RELEASE) || (state_q == RUN));

  always_comb begin
    state_d    = state_q;
    stb_cnt_d  = stb_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sw_cnt_d   = sw_cnt_q;
    sw_req_d   = (state_q == RUN) ? sw_rst_req_i : '0;
    dom_rstn_d = dom_rstn_q;
    rst_done_d = rst_done_q;
    loss_cnt_d = loss_cnt_q;

    case (state_q)
      IDLE: begin
        dom_rstn_d = '0;
        rst_done_d = 1'b0;
        sw_cnt_d   = '0;
        if (locked_s) begin
          state_d   = STABLE;
          stb_cnt_d = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = IDLE;
        end else if (stb_cnt_q == STB_W'(LOCK_STABLE_CYC - 1)) begin
          gap_cnt_d  = '0;
          dom_rstn_d = N_DOM'(1);
          if (N_DOM == 1) begin
            state_d    = RUN;
            rst_done_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      RELEASE: begin
        if (gap_cnt_q == GAP_W'(STAGE_GAP_CYC - 1)) begin
          gap_cnt_d  = '0;
          dom_rstn_d = next_rel;
          if (&next_rel) begin
            state_d    = RUN;
            rst_done_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      RUN: begin
        // Counter holds the remaining low cycles; a fresh request reloads it.
        for (int unsigned k = 0; k < N_DOM; k++) begin
          if (sw_req_q[k]) begin
            sw_cnt_d[k] = SW_W'(SW_RST_CYC);
          end else if (sw_cnt_q[k] != '0) begin
            sw_cnt_d[k] = sw_cnt_q[k] - SW_W'(1);
          end
          dom_rstn_d[k] = (sw_cnt_d[k] == '0);
        end
        rst_done_d = &dom_rstn_d;
      end
      default: state_d = IDLE;
    endcase

    // Lock loss overrides release progress and any software request.
    if (lock_loss_c) begin
      state_d    = IDLE;
      dom_rstn_d = '0;
      rst_done_d = 1'b0;
      sw_cnt_d   = '0;
      sw_req_d   = '0;
      loss_cnt_d = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + LOCK_CNT_W'(1);
    end
  end

  assign dom_rstn_o      = dom_rstn_q;
  assign rst_done_o      = rst_done_q;
  assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_rgu_seq.sv
// Directed self-checking bench for rgu_seq at default parameters.
module tb_rgu_seq;
  import rgu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  rgu_seq_if #(.N_DOM(4)) bus ();

  int n_assert = 0;
  int n_fail   = 0;

  rgu_seq #(
    .N_DOM           (4),
    .LOCK_STABLE_CYC (16),
    .STAGE_GAP_CYC   (8),
    .SW_RST_CYC      (4)
  ) dut (
    .sys_clk_i       (clk),
    .por_rstn_i      (rst_n),
    .locked_i        (bus.locked),
    .sw_rst_req_i    (bus.sw_rst_req),
    .dom_rstn_o      (bus.dom_rstn),
    .rst_done_o      (bus.rst_done),
    .lock_loss_cnt_o (bus.lock_loss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] dom, input logic done);
    check({tag, "_dom"}, 32'(bus.dom_rstn), 32'(dom));
    check({tag, "_done"}, 32'(bus.rst_done), 32'(done));
  endtask

  initial begin
    bus.locked     = 1'b0;
    bus.sw_rst_req = 4'b0000;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk_out("por", 4'b0000, 1'b0);
    check("por_cnt", 32'(bus.lock_loss_cnt), 32'd0);
    tick(2);
    rst_n = 1'b1;

    // Glitchy lock: 10 high, 1 low, then held high (E0' = restart edge)
    bus.locked = 1'b1;
    tick(1);
    tick(9);
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    tick(1);
    tick(7);
    chk_out("glitch_orig18", 4'b0000, 1'b0);
    tick(10);
    chk_out("glitch_e17", 4'b0000, 1'b0);
    tick(1);
    chk_out("glitch_e18", 4'b0001, 1'b0);
    check("glitch_cnt", 32'(bus.lock_loss_cnt), 32'd0);

    // Asynchronous POR mid-RELEASE, between edges
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_por", 4'b0000, 1'b0);
    check("async_por_cnt", 32'(bus.lock_loss_cnt), 32'd0);
    #2 rst_n = 1'b1;

    // Cold lock, locked_i held high from before E0
    tick(1);
    tick(17);
    chk_out("cold_e17", 4'b0000, 1'b0);
    tick(1);
    chk_out("cold_e18", 4'b0001, 1'b0);
    tick(7);
    chk_out("cold_e25", 4'b0001, 1'b0);
    tick(1);
    chk_out("cold_e26", 4'b0011, 1'b0);
    tick(8);
    chk_out("cold_e34", 4'b0111, 1'b0);
    bus.sw_rst_req = 4'b1111;
    tick(7);
    chk_out("cold_e41", 4'b0111, 1'b0);
    tick(1);
    chk_out("cold_e42", 4'b1111, 1'b1);
    check("cold_cnt", 32'(bus.lock_loss_cnt), 32'd0);
    bus.sw_rst_req = 4'b0000;
    tick(1);
    chk_out("sw_ignored", 4'b1111, 1'b1);

    // Software reset 4'b0101, single-cycle request
    bus.sw_rst_req = 4'b0101;
    tick(1);
    bus.sw_rst_req = 4'b0000;
    chk_out("sw_lat", 4'b1111, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk_out("sw_pulse", 4'b1010, 1'b0);
    end
    tick(1);
    chk_out("sw_end", 4'b1111, 1'b1);

    // Retrigger domain 0 two cycles after the first request
    bus.sw_rst_req = 4'b0101;
    tick(1);
    bus.sw_rst_req = 4'b0000;
    tick(1);
    chk_out("sw2_e1", 4'b1010, 1'b0);
    bus.sw_rst_req = 4'b0001;
    tick(1);
    bus.sw_rst_req = 4'b0000;
    tick(2);
    chk_out("sw2_e4", 4'b1010, 1'b0);
    tick(1);
    chk_out("sw2_e5", 4'b1110, 1'b0);
    tick(1);
    chk_out("sw2_e6", 4'b1110, 1'b0);
    tick(1);
    chk_out("sw2_e7", 4'b1111, 1'b1);

    // Lock loss in RUN
    bus.locked = 1'b0;
    tick(1);
    chk_out("loss_f0", 4'b1111, 1'b1);
    tick(1);
    chk_out("loss_f1", 4'b1111, 1'b1);
    tick(1);
    chk_out("loss_f2", 4'b0000, 1'b0);
    check("loss_cnt1", 32'(bus.lock_loss_cnt), 32'd1);

    bus.locked = 1'b1;
    tick(1);
    tick(17);
    chk_out("relock_e17", 4'b0000, 1'b0);
    tick(1);
    chk_out("relock_e18", 4'b0001, 1'b0);
    tick(24);
    chk_out("relock_e42", 4'b1111, 1'b1);

    // Lock loss during a software pulse on domain 0
    bus.sw_rst_req = 4'b0001;
    tick(1);
    bus.sw_rst_req = 4'b0000;
    tick(1);
    chk_out("swloss_e1", 4'b1110, 1'b0);
    bus.locked = 1'b0;
    tick(2);
    chk_out("swloss_f1", 4'b1110, 1'b0);
    tick(1);
    chk_out("swloss_f2", 4'b0000, 1'b0);
    check("loss_cnt2", 32'(bus.lock_loss_cnt), 32'd2);

    bus.locked = 1'b1;
    tick(1);
    tick(17);
    chk_out("swrelock_e17", 4'b0000, 1'b0);
    tick(1);
    chk_out("swrelock_e18", 4'b0001, 1'b0);

    // Lock loss during RELEASE
    tick(2);
    bus.locked = 1'b0;
    tick(2);
    chk_out("relloss_f1", 4'b0001, 1'b0);
    tick(1);
    chk_out("relloss_f2", 4'b0000, 1'b0);
    check("loss_cnt3", 32'(bus.lock_loss_cnt), 32'd3);

    // Drive the loss counter to saturation (300 events total)
    for (int i = 3; i < 300; i++) begin
      bus.locked = 1'b1;
      tick(19);
      bus.locked = 1'b0;
      tick(3);
      if (i == 254) check("loss_cnt255", 32'(bus.lock_loss_cnt), 32'd255);
    end
    check("loss_sat", 32'(bus.lock_loss_cnt), 32'd255);
    chk_out("loss_sat", 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
